// File: rtl/nfc_pkg.sv
// rtl/nfc_pkg.sv - shared types and constants for the NAND write data buffer
package nfc_pkg;

    localparam int PAGE_BYTES_DEF = 512;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } unpk_state_t;

    // Width of the index that selects one byte lane out of a word of word_bytes bytes.
    function automatic int lane_sel_w(input int word_bytes);
        int w;
        w = 0;
        while ((1 << w) < word_bytes) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/nfc_word_fifo.sv
// rtl/nfc_word_fifo.sv - DEPTHx32 circular word FIFO with level counter and flush
module nfc_word_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic          pop,
    output logic [31:0]   pop_data,
    output logic [AW:0]   level
);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/nand_write_data_buffer.sv
// rtl/nand_write_data_buffer.sv - word FIFO + byte unpacker feeding the NAND page writer; page checksum under NFC_WRBUF_PAGE_XOR_EN
module nand_write_data_buffer
    import nfc_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int PAGE_BYTES = PAGE_BYTES_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          wr_valid,
    input  logic [31:0]                   wr_data,
    output logic                          wr_ready,
    input  logic                          data_get,
    output logic [7:0]                    byte_out,
    output logic                          byte_valid,
    output logic [AW:0]                   level,
    output logic [$clog2(PAGE_BYTES)-1:0] page_byte_cnt,
    output logic                          page_done,
    output logic                          overflow,
    output logic                          underflow,
    output logic [7:0]                    page_xor
);

    localparam int LW = lane_sel_w(4);

    unpk_state_t   state, state_nxt;
    logic [LW-1:0] idx;
    logic [31:0]   word;
    logic [31:0]   fifo_dout;
    logic          push;
    logic          pop;
    logic          consume;
    logic          last_lane;
    logic          has_word;
    logic          page_wrap;

    assign wr_ready  = (level != (AW+1)'(DEPTH));
    assign push      = wr_valid && wr_ready && !flush && !rst;
    assign has_word  = (level != '0);
    assign last_lane = (idx == LW'(3));

    nfc_word_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .level     (level)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) state <= ST_EMPTY;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (has_word) state_nxt = ST_HOLD;
            ST_HOLD:  if (data_get && last_lane && !has_word) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Reloading on the last lane's data_get keeps back-to-back reads bubble-free.
    always_comb begin
        byte_valid = (state == ST_HOLD);
        byte_out   = byte_valid ? word[{idx, 3'b000} +: 8] : 8'h00;
        pop        = !rst && !flush && has_word &&
                     ((state == ST_EMPTY) || (state == ST_HOLD && data_get && last_lane));
    end

    assign consume = data_get && byte_valid && !flush && !rst;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            idx  <= '0;
            word <= '0;
        end else if (pop) begin
            idx  <= '0;
            word <= fifo_dout;
        end else if (consume) begin
            idx  <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!flush) begin
            if (wr_valid && !wr_ready)   overflow  <= 1'b1;
            if (data_get && !byte_valid) underflow <= 1'b1;
        end
    end

    assign page_wrap = consume && (&page_byte_cnt);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            page_byte_cnt <= '0;
            page_done     <= 1'b0;
        end else begin
            page_done <= page_wrap;
            if (consume) page_byte_cnt <= page_byte_cnt + 1'b1;
        end
    end

`ifdef NFC_WRBUF_PAGE_XOR_EN
    logic [7:0] xor_acc;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            xor_acc  <= 8'h00;
            page_xor <= 8'h00;
        end else if (page_wrap) begin
            xor_acc  <= 8'h00;
            page_xor <= xor_acc ^ byte_out;
        end else if (consume) begin
            xor_acc  <= xor_acc ^ byte_out;
        end
    end
`else
    assign page_xor = 8'h00;
`endif

endmodule

// File: tb/tb_nand_write_data_buffer.sv
// tb/tb_nand_write_data_buffer.sv - self-checking bench for nand_write_data_buffer
module tb_nand_write_data_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic        data_get = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [4:0]  level;
    logic [8:0]  page_byte_cnt;
    logic        page_done;
    logic        overflow;
    logic        underflow;
    logic [7:0]  page_xor;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nand_write_data_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .data_get      (data_get),
        .byte_out      (byte_out),
        .byte_valid    (byte_valid),
        .level         (level),
        .page_byte_cnt (page_byte_cnt),
        .page_done     (page_done),
        .overflow      (overflow),
        .underflow     (underflow),
        .page_xor      (page_xor)
    );

    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic        get;
        logic        exp_bv;
        logic [7:0]  exp_byte;
        logic [4:0]  exp_level;
        logic [8:0]  exp_cnt;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; data_get = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] mk(input int base);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(base); b1 = 8'(base + 1); b2 = 8'(base + 2); b3 = 8'(base + 3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic [7:0] page_byte(input int b, input logic [7:0] first);
        return (b == 0) ? first : 8'(b);
    endfunction

    task automatic run_page(input logic [7:0] first);
        int sent, got, pd, cyc;
        logic acc;
        logic [7:0] exp_xor;
        sent = 0; got = 0; pd = 0; exp_xor = 8'h00;
        do_reset();
        for (cyc = 0; cyc < 3000 && got < 512; cyc++) begin
            wr_valid = (sent < 128);
            wr_data  = {page_byte(4*sent+3, first), page_byte(4*sent+2, first),
                        page_byte(4*sent+1, first), page_byte(4*sent, first)};
            data_get = byte_valid;
            if (byte_valid) begin
                if (byte_out !== page_byte(got, first))
                    chk("page_stream_byte", {24'h0, byte_out}, {24'h0, page_byte(got, first)});
                exp_xor ^= page_byte(got, first);
            end
            acc = wr_valid && wr_ready;
            tick();
            if (acc) sent++;
            if (data_get) got++;
            if (page_done) begin
                pd++;
                chk("page_done_at_512", got, 512);
                chk("page_cnt_at_done", {23'h0, page_byte_cnt}, 32'h0);
            end
        end
        wr_valid = 1'b0; data_get = 1'b0;
        chk("page_bytes_consumed", got, 512);
        tick();
        chk("page_done_single", pd, 1);
        chk("page_done_cleared", {31'h0, page_done}, 32'h0);
`ifdef NFC_WRBUF_PAGE_XOR_EN
        chk("page_xor", {24'h0, page_xor}, {24'h0, exp_xor});
`else
        chk("page_xor_tied", {24'h0, page_xor}, 32'h0);
`endif
    endtask

    initial begin
        // Basic ordering, then a second burst that exercises the no-bubble reload.
        tbl[0]  = '{1'b1, 32'h44332211, 1'b0, 1'b0, 8'h00, 5'd1, 9'd0};
        tbl[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 8'h11, 5'd0, 9'd0};
        tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h22, 5'd0, 9'd1};
        tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h33, 5'd0, 9'd2};
        tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h44, 5'd0, 9'd3};
        tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 8'h00, 5'd0, 9'd4};
        tbl[6]  = '{1'b1, 32'hA0B0C0D0, 1'b0, 1'b0, 8'h00, 5'd1, 9'd4};
        tbl[7]  = '{1'b1, 32'h04030201, 1'b0, 1'b1, 8'hD0, 5'd1, 9'd4};
        tbl[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hC0, 5'd1, 9'd5};
        tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hB0, 5'd1, 9'd6};
        tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'hA0, 5'd1, 9'd7};
        tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h01, 5'd0, 9'd8};
        tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 8'h02, 5'd0, 9'd9};

        do_reset();
        chk("rst_byte_valid", {31'h0, byte_valid}, 32'h0);
        chk("rst_byte_out", {24'h0, byte_out}, 32'h0);
        chk("rst_wr_ready", {31'h0, wr_ready}, 32'h1);
        chk("rst_level", {27'h0, level}, 32'h0);
        chk("rst_page_cnt", {23'h0, page_byte_cnt}, 32'h0);
        chk("rst_page_done", {31'h0, page_done}, 32'h0);
        chk("rst_flags", {30'h0, overflow, underflow}, 32'h0);
        chk("rst_page_xor", {24'h0, page_xor}, 32'h0);

        for (int i = 0; i < 13; i++) begin
            wr_valid = tbl[i].wv; wr_data = tbl[i].wd; data_get = tbl[i].get;
            tick();
            chk($sformatf("vec%0d_bv", i), {31'h0, byte_valid}, {31'h0, tbl[i].exp_bv});
            chk($sformatf("vec%0d_byte", i), {24'h0, byte_out}, {24'h0, tbl[i].exp_byte});
            chk($sformatf("vec%0d_level", i), {27'h0, level}, {27'h0, tbl[i].exp_level});
            chk($sformatf("vec%0d_cnt", i), {23'h0, page_byte_cnt}, {23'h0, tbl[i].exp_cnt});
        end
        wr_valid = 1'b0; data_get = 1'b0;

        // Back-to-back: 12 consecutive data_get pulses across 3 words.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = mk(4*i);
            tick();
        end
        wr_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            data_get = 1'b1;
            chk($sformatf("b2b_bv%0d", k), {31'h0, byte_valid}, 32'h1);
            chk($sformatf("b2b_byte%0d", k), {24'h0, byte_out}, k);
            tick();
        end
        data_get = 1'b0;
        chk("b2b_drained", {31'h0, byte_valid}, 32'h0);
        chk("b2b_cnt", {23'h0, page_byte_cnt}, 12);

        // Full: one word sits in the unpacker, so 17 accepts fill the 16-deep FIFO.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1'b1; wr_data = mk(8'h40 + 4*i);
            tick();
        end
        chk("full_level", {27'h0, level}, 16);
        chk("full_wr_ready", {31'h0, wr_ready}, 32'h0);
        chk("full_no_ovf_yet", {31'h0, overflow}, 32'h0);
        wr_data = 32'hFFFFFFFF;
        tick();
        wr_valid = 1'b0;
        chk("ovf_set", {31'h0, overflow}, 32'h1);
        chk("ovf_level", {27'h0, level}, 16);
        for (int k = 0; k < 68; k++) begin
            data_get = 1'b1;
            chk($sformatf("drain_byte%0d", k), {24'h0, byte_out}, 32'(8'(8'h40 + k)));
            tick();
        end
        data_get = 1'b0;
        chk("drain_bv_low", {31'h0, byte_valid}, 32'h0);
        chk("drain_level", {27'h0, level}, 32'h0);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_keeps_ovf", {31'h0, overflow}, 32'h1);

        // Underflow.
        do_reset();
        chk("udf_clear", {31'h0, underflow}, 32'h0);
        data_get = 1'b1; tick(); data_get = 1'b0;
        chk("udf_set", {31'h0, underflow}, 32'h1);
        chk("udf_bv", {31'h0, byte_valid}, 32'h0);
        chk("udf_byte", {24'h0, byte_out}, 32'h0);
        chk("udf_level", {27'h0, level}, 32'h0);
        chk("udf_cnt", {23'h0, page_byte_cnt}, 32'h0);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_keeps_udf", {31'h0, underflow}, 32'h1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_clears_udf", {31'h0, underflow}, 32'h0);

        // Page wrap, plain and with a modified first byte.
        run_page(8'h00);
        run_page(8'h5A);

        // Flush mid-word with a same-cycle write.
        do_reset();
        wr_valid = 1'b1; wr_data = 32'h13121110; tick();
        wr_data = 32'h17161514; tick();
        wr_valid = 1'b0;
        chk("fm_first_byte", {24'h0, byte_out}, 32'h10);
        data_get = 1'b1; tick(); tick(); data_get = 1'b0;
        chk("fm_third_byte", {24'h0, byte_out}, 32'h12);
        flush = 1'b1; wr_valid = 1'b1; wr_data = 32'hDEADBEEF;
        tick();
        flush = 1'b0; wr_valid = 1'b0;
        chk("fm_bv", {31'h0, byte_valid}, 32'h0);
        chk("fm_level", {27'h0, level}, 32'h0);
        chk("fm_cnt", {23'h0, page_byte_cnt}, 32'h0);
        tick();
        chk("fm_write_dropped", {27'h0, level}, 32'h0);
        wr_valid = 1'b1; wr_data = 32'h2B2A2920; tick();
        wr_valid = 1'b0; tick();
        chk("fm_new_bv", {31'h0, byte_valid}, 32'h1);
        chk("fm_new_byte0", {24'h0, byte_out}, 32'h20);
        data_get = 1'b1; tick(); data_get = 1'b0;
        chk("fm_new_byte1", {24'h0, byte_out}, 32'h29);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
